// File: rtl/div_mon_pkg.sv
// div_mon_pkg: shared types and helpers for the divided-clock duty monitor.
//   - mon_state_e : monitor FSM states (SYNC, TRACK)
//   - DEF_*       : default DIV / LOCK_N / CW values
//   - half_step() : next half-cycle counter values and rise flag for one sample
// Counters are carried at MAX_CW bits inside the helper so that one function
// serves every CW; callers zero-extend on entry and truncate on exit.
package div_mon_pkg;

  typedef enum logic [0:0] {
    SYNC  = 1'b0,
    TRACK = 1'b1
  } mon_state_e;

  localparam int unsigned DEF_DIV    = 3;
  localparam int unsigned DEF_LOCK_N = 4;
  localparam int unsigned DEF_CW     = 6;
  localparam int unsigned MAX_CW     = 16;

  localparam logic [MAX_CW-1:0] CNT_ONE = {{(MAX_CW-1){1'b0}}, 1'b1};

  typedef struct packed {
    logic [MAX_CW-1:0] hi;
    logic [MAX_CW-1:0] lo;
    logic              rise;
  } half_step_t;

  // On a rise the counters restart with the current (high) sample already
  // counted; otherwise the matching counter advances, saturating at cnt_max.
  function automatic half_step_t half_step(input logic [MAX_CW-1:0] hi,
                                           input logic [MAX_CW-1:0] lo,
                                           input logic [MAX_CW-1:0] cnt_max,
                                           input logic              prev,
                                           input logic              smp);
    half_step_t r;
    r.rise = ~prev & smp;
    if (r.rise) begin
      r.hi = CNT_ONE;
      r.lo = '0;
    end else if (smp) begin
      r.hi = (hi == cnt_max) ? hi : hi + CNT_ONE;
      r.lo = lo;
    end else begin
      r.hi = hi;
      r.lo = (lo == cnt_max) ? lo : lo + CNT_ONE;
    end
    return r;
  endfunction

endpackage

// File: rtl/div_mon_edge_sampler.sv
// div_mon_edge_sampler: half-cycle sampling front end of the duty monitor.
// Ports:
//   clk_i    reference clock
//   rst_ni   asynchronous active-low reset
//   div_i    divided clock under test
//   s_neg_o  div_i captured on the falling edge of clk_i (older half, h0)
//   s_pos_o  rising-edge half (h1); it is captured by the monitor's own
//            rising-edge state flops, so it is passed straight through here
// The falling-edge flop lives alone in this module so it can be constrained
// and scan-stitched on its own.
module div_mon_edge_sampler (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic div_i,
  output logic s_neg_o,
  output logic s_pos_o
);

  logic s_neg_q;

  // Falling-edge capture of the divided clock.
  always_ff @(negedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      s_neg_q <= 1'b0;
    end else begin
      s_neg_q <= div_i;
    end
  end

  assign s_neg_o = s_neg_q;
  assign s_pos_o = div_i;

endmodule

// File: rtl/div_duty_monitor.sv
// div_duty_monitor: checks an odd-ratio 50%-duty divided clock at half-cycle
// resolution, reports per-period high/low time, lock and a sticky error.
// Parameters: DIV (expected ratio), LOCK_N (good periods to lock),
//             CW (half-cycle counter width, 2^CW-1 > 2*DIV, CW <= 16).
// Ports:
//   clk, rst_n     reference clock, async active-low reset
//   div_in         divided clock under test
//   period_valid   one-cycle pulse per period verdict
//   meas_high/low  high/low half-cycles of the last closed period
//   locked         LOCK_N consecutive good periods since the last fault
//   err            sticky fault flag, cleared only by reset
//   bad_cnt        saturating bad-period count (tied to 0 unless the
//                  DIV_MON_STATS_EN macro is defined)
module div_duty_monitor
  import div_mon_pkg::*;
#(
  parameter int unsigned DIV    = DEF_DIV,
  parameter int unsigned LOCK_N = DEF_LOCK_N,
  parameter int unsigned CW     = DEF_CW
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          div_in,
  output logic          period_valid,
  output logic [CW-1:0] meas_high,
  output logic [CW-1:0] meas_low,
  output logic          locked,
  output logic          err,
  output logic [3:0]    bad_cnt
);

  localparam int unsigned GW = (LOCK_N < 2) ? 1 : $clog2(LOCK_N + 1);
  localparam logic [MAX_CW-1:0] CNT_MAX = MAX_CW'((32'd1 << CW) - 32'd1);
  localparam logic [CW-1:0]     DIV_C   = CW'(DIV);
  localparam logic [CW-1:0]     STALL_C = CW'(2 * DIV);
  localparam logic [GW-1:0]     LOCK_C  = GW'(LOCK_N);

  logic          s_neg_s, s_pos_s;
  logic [1:0]    smp_s;
  half_step_t    step_s;
  logic [CW-1:0] nh_s, nl_s;
  logic          bad_hit_s;

  mon_state_e    state_q, state_d;
  logic [CW-1:0] hi_q, hi_d, lo_q, lo_d;
  logic [CW-1:0] meas_hi_q, meas_hi_d, meas_lo_q, meas_lo_d;
  logic [GW-1:0] good_q, good_d;
  logic          prev_q, prev_d;
  logic          valid_q, valid_d;
  logic          locked_q, locked_d;
  logic          err_q, err_d;

  div_mon_edge_sampler u_sampler (
    .clk_i   (clk),
    .rst_ni  (rst_n),
    .div_i   (div_in),
    .s_neg_o (s_neg_s),
    .s_pos_o (s_pos_s)
  );

  // Next-state logic: walk the two half samples oldest first. Because prev
  // chains from h0 into h1, a rise on h0 forces h0=1 and rules out a second
  // rise on h1, so at most one verdict is produced per clock.
  always_comb begin
    state_d   = state_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    prev_d    = prev_q;
    good_d    = good_q;
    locked_d  = locked_q;
    err_d     = err_q;
    meas_hi_d = meas_hi_q;
    meas_lo_d = meas_lo_q;
    valid_d   = 1'b0;
    bad_hit_s = 1'b0;
    step_s    = '0;
    nh_s      = '0;
    nl_s      = '0;
    smp_s     = {s_pos_s, s_neg_s};
    for (int i = 0; i < 2; i++) begin
      step_s = half_step(MAX_CW'(hi_d), MAX_CW'(lo_d), CNT_MAX, prev_d, smp_s[i]);
      nh_s   = step_s.hi[CW-1:0];
      nl_s   = step_s.lo[CW-1:0];
      prev_d = smp_s[i];
      case (state_d)
        SYNC: begin
          // Partial first period is discarded: start counting at the rise.
          if (step_s.rise) begin
            hi_d    = nh_s;
            lo_d    = nl_s;
            state_d = TRACK;
          end else begin
            hi_d = '0;
            lo_d = '0;
          end
        end
        TRACK: begin
          if (step_s.rise) begin
            valid_d   = 1'b1;
            meas_hi_d = hi_d;
            meas_lo_d = lo_d;
            if ((hi_d == DIV_C) && (lo_d == DIV_C)) begin
              if (good_d != LOCK_C) begin
                good_d = good_d + GW'(1'b1);
              end else begin
                good_d = good_d;
              end
              locked_d = (good_d == LOCK_C);
            end else begin
              good_d    = '0;
              locked_d  = 1'b0;
              err_d     = 1'b1;
              bad_hit_s = 1'b1;
            end
            hi_d = nh_s;
            lo_d = nl_s;
          end else if ((nh_s > STALL_C) || (nl_s > STALL_C)) begin
            // Stalled clock: no verdict, resynchronise on the next rise.
            err_d    = 1'b1;
            locked_d = 1'b0;
            good_d   = '0;
            hi_d     = '0;
            lo_d     = '0;
            state_d  = SYNC;
          end else begin
            hi_d = nh_s;
            lo_d = nl_s;
          end
        end
        default: begin
          hi_d    = '0;
          lo_d    = '0;
          state_d = SYNC;
        end
      endcase
    end
  end

  // Monitor state and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= SYNC;
      hi_q      <= '0;
      lo_q      <= '0;
      prev_q    <= 1'b1;
      good_q    <= '0;
      locked_q  <= 1'b0;
      err_q     <= 1'b0;
      meas_hi_q <= '0;
      meas_lo_q <= '0;
      valid_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      prev_q    <= prev_d;
      good_q    <= good_d;
      locked_q  <= locked_d;
      err_q     <= err_d;
      meas_hi_q <= meas_hi_d;
      meas_lo_q <= meas_lo_d;
      valid_q   <= valid_d;
    end
  end

`ifdef DIV_MON_STATS_EN
  logic [3:0] bad_q;

  // Saturating count of bad-period verdicts; stalls are not counted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bad_q <= 4'd0;
    end else if (bad_hit_s && (bad_q != 4'd15)) begin
      bad_q <= bad_q + 4'd1;
    end else begin
      bad_q <= bad_q;
    end
  end

  assign bad_cnt = bad_q;
`else
  logic unused_bad_hit_s;
  assign unused_bad_hit_s = bad_hit_s;
  assign bad_cnt          = 4'd0;
`endif

  assign period_valid = valid_q;
  assign meas_high    = meas_hi_q;
  assign meas_low     = meas_lo_q;
  assign locked       = locked_q;
  assign err          = err_q;

endmodule

// File: doc/div_duty_monitor.md
# div_duty_monitor

Downstream checker for the odd-ratio 50%-duty clock divider. Samples the divided clock against the reference clock that drives the divider, at half-cycle resolution on both clock edges. Measures the high and low time of every divided period and flags period/duty errors. Declares lock after a run of consecutive good periods.

## Interface
- `DIV`, default 3: expected divide ratio. Good period = `DIV` high half-cycles followed by `DIV` low half-cycles.
- `LOCK_N`, default 4: number of consecutive good periods required to assert `locked`.
- `CW`, default 6: width of the half-cycle counters. Must satisfy 2^CW-1 > 2*DIV.

Ports:
- `clk`, input, 1: reference clock (the divider's input clock; maps to io_in[0]).
- `rst_n`, input, 1: reset. Asynchronous, active-low (maps to io_in[1]).
- `div_in`, input, 1: divided clock under test.
- `period_valid`, output, 1: one-cycle pulse when a period verdict is produced.
- `meas_high`, output, CW: high half-cycles of the last measured period.
- `meas_low`, output, CW: low half-cycles of the last measured period.
- `locked`, output, 1: LOCK_N consecutive good periods seen since the last fault.
- `err`, output, 1: sticky fault flag. Cleared only by reset.
- `bad_cnt`, output, 4: saturating count of bad periods. Present only with `DIV_MON_STATS_EN`.

## Operation
- **Sampling.**
  - `s_neg` captures `div_in` on the falling edge of `clk`.
  - `s_pos` captures `div_in` on the rising edge of `clk`.
  - All other logic is on the rising edge.
  - Each rising edge processes the ordered pair (h0=`s_neg`, h1=`s_pos`), i.e. two half-cycle samples, oldest first.
- **Per half-sample update**, combinational, applied twice per cycle in order h0 then h1:
  - A rising edge is the previous sample 0 and the current sample 1.
  - A high sample increments `hi_cnt`; a low sample increments `lo_cnt`.
  - Both counters saturate at 2^CW-1.
- **Initial previous sample.** `prev` resets to 1, so a `div_in` already high at reset release is not treated as an edge.
- **FSM states: SYNC, TRACK.**
  - **SYNC:** counters are held at 0. On a rising edge: clear counters, count the current sample, go to TRACK. The first, partial period is discarded.
  - **TRACK, on a rising edge:**
    - Close the period and latch `meas_high`/`meas_low`.
    - Pulse `period_valid`.
    - Restart the counters with the current sample counted.
    - Good period iff hi==DIV and lo==DIV. A good period increments `good_cnt` (saturates at LOCK_N); `locked` goes high when `good_cnt` reaches LOCK_N.
    - Bad period: `good_cnt`=0, `locked`=0, `err`=1. The FSM stays in TRACK.
  - **TRACK, stall:** if `hi_cnt` or `lo_cnt` exceeds 2*DIV, then `err`=1, `locked`=0, `good_cnt`=0, go to SYNC. No `period_valid` pulse.
- **Two rising edges in one pair** are impossible for any `div_in` that changes at most once per half-cycle. If it occurs, only the h1 edge closes a period, and the period is judged bad.

## Timing
- **Reset values:** `period_valid`=0, `meas_high`=0, `meas_low`=0, `locked`=0, `err`=0, `bad_cnt`=0. FSM=SYNC, `prev`=1, sampling flops=0.
- **Async reset mid-operation:** all outputs clear immediately. After release, operation restarts in SYNC.
- **Verdict latency:** `period_valid`, `meas_*`, `locked` and `err` update at the rising edge that samples the first high half after the `div_in` rise. Latency is at most one `clk` period after the edge.
- **Lock latency:** `locked` rises with the verdict of the LOCK_N-th good period, which is the (LOCK_N+1)-th rising edge of `div_in` after SYNC.
- **Stall detection:** at the rising edge where a counter first reaches 2*DIV+1.

## Configuration
- **`DIV_MON_STATS_EN` defined:** a 4-bit `bad_cnt` increments on each bad-period verdict and saturates at 15. Stall events do not count.
- **Undefined:** the counter is not built and `bad_cnt` is tied to 0.

## Structure
- Shared package `div_mon_pkg`, holding:
  - FSM state enum (SYNC, TRACK).
  - Default DIV/LOCK_N/CW localparams.
  - A function computing the next counter and edge state for one half-sample.
- One sub-module, `div_mon_edge_sampler`: the dual-edge sampling flops. It isolates the negedge flop for timing and DFT.

## Test plan
- **Real divide-by-3 divider output on `div_in`:** `locked`=1 at the 5th `div_in` rise. Every verdict has `meas_high`=3, `meas_low`=3, and `err` stays 0.
- **`div_in` = clk/3 at 33% duty (2 high halves, 4 low):** every verdict has `meas_high`=2, `meas_low`=4, with `err`=1 and `locked`=0.
- **`div_in` forced to 0 after lock:** once `lo_cnt` reaches 7, `err`=1, `locked`=0, FSM=SYNC, and no `period_valid` pulse.
- **One bad period (high=4, low=2) injected after lock, then good periods:** `locked` drops on that verdict and returns after 4 further good verdicts. `err` stays 1.
- **`rst_n` pulsed low mid-period while locked:** all outputs are 0 before the next `clk` edge. The first post-reset rise produces no verdict.
- **With `DIV_MON_STATS_EN`:** 3 bad periods give `bad_cnt`=3; 20 bad periods give `bad_cnt`=15.
